// File: rtl/prn_free_list_ckpt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prn_free_list_ckpt_pkg                                                     |
// | Shared widths, checkpoint record type and pointer-width helper.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package prn_free_list_ckpt_pkg;

   // Ring pointers carry one extra wrap bit above the index.
   function automatic int calc_ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int PRF_W  = $clog2(64);
   localparam int PTR_W  = calc_ptr_w(64 - 32);
   localparam int CKPT_W = $clog2(4);

   typedef struct packed {
      logic [PTR_W-1:0] head;
      logic             valid;
   } free_list_ckpt_t;

endpackage
`default_nettype wire

// File: rtl/prn_free_list_ckpt_lane_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lane_compactor                                                             |
// | Exclusive prefix sum of a lane-valid vector: per-lane offset and total.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lane_compactor
   import prn_free_list_ckpt_pkg::*;
#(
   parameter int LANES = 2,
   parameter int CNT_W = $clog2(LANES + 1)
) (
   input  logic [LANES-1:0] valid,
   output logic [CNT_W-1:0] offset [LANES],
   output logic [CNT_W-1:0] total
);

   always_comb begin
      logic [CNT_W-1:0] v_sum;
      v_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         offset[i] = v_sum;
         v_sum     = v_sum + CNT_W'(valid[i]);
      end
      total = v_sum;
   end

endmodule
`default_nettype wire

// File: rtl/prn_free_list_ckpt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prn_free_list_ckpt                                                         |
// | Circular PRN free list: N-wide allocate, M-wide release, branch checkpoints|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module prn_free_list_ckpt
   import prn_free_list_ckpt_pkg::*;
#(
   parameter int ALLOC_W   = 2,
   parameter int RET_W     = 2,
   parameter int PRF_DEPTH = 64,
   parameter int ARF_DEPTH = 32,
   parameter int NUM_CKPT  = 4,
   parameter int FL_DEPTH  = PRF_DEPTH - ARF_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   output logic [$clog2(PRF_DEPTH)-1:0]  alloc_prn [ALLOC_W],
   output logic [ALLOC_W-1:0]            alloc_valid,
   input  logic [ALLOC_W-1:0]            alloc_ready,
   input  logic [$clog2(PRF_DEPTH)-1:0]  ret_prn_prev [RET_W],
   input  logic [RET_W-1:0]              ret_valid,
   input  logic                          ckpt_save,
   input  logic                          ckpt_restore,
   input  logic [$clog2(NUM_CKPT)-1:0]   ckpt_tag,
   input  logic                          recov_arch_st,
   output logic [$clog2(FL_DEPTH):0]     free_cnt
);

   localparam int c_prf_w  = $clog2(PRF_DEPTH);
   localparam int c_idx_w  = $clog2(FL_DEPTH);
   localparam int c_ptr_w  = calc_ptr_w(FL_DEPTH);
   localparam int c_rcnt_w = $clog2(RET_W + 1);

   logic [c_prf_w-1:0]  r_ring [FL_DEPTH];
   logic [c_ptr_w-1:0]  r_head;
   logic [c_ptr_w-1:0]  r_commit_head;
   logic [c_ptr_w-1:0]  r_tail;
   logic [c_ptr_w-1:0]  r_ckpt_head [NUM_CKPT];

   logic                w_alloc_block;
   logic [c_ptr_w-1:0]  w_alloc_cnt;
   logic [c_ptr_w-1:0]  w_head_alloc;
   logic [c_ptr_w-1:0]  w_head_nxt;
   logic [c_ptr_w-1:0]  w_ckpt_sel;
   logic [c_ptr_w-1:0]  w_ret_cnt;
   logic [c_rcnt_w-1:0] w_ret_off [RET_W];
   logic [c_rcnt_w-1:0] w_ret_total;
   logic [c_idx_w-1:0]  w_wr_idx [RET_W];
   logic [c_ptr_w-1:0]  w_rst_dist;
   logic [c_ptr_w-1:0]  w_head_dist;

   assign free_cnt      = r_tail - r_head;
   assign w_alloc_block = recov_arch_st | ckpt_restore;

   generate
      for (genvar i = 0; i < ALLOC_W; i++) begin : g_alloc_lane
         logic [c_ptr_w-1:0] w_rd_ptr;
         assign w_rd_ptr       = r_head + c_ptr_w'(i);
         assign alloc_prn[i]   = r_ring[w_rd_ptr[c_idx_w-1:0]];
         assign alloc_valid[i] = rst_n & ~w_alloc_block & (free_cnt > c_ptr_w'(i));
      end
   endgenerate

   // Only the leading run of valid&ready lanes is granted; a ready lane after a gap waits.
   always_comb begin
      logic v_run;
      v_run       = 1'b1;
      w_alloc_cnt = '0;
      for (int i = 0; i < ALLOC_W; i++) begin
         v_run       = v_run & alloc_valid[i] & alloc_ready[i];
         w_alloc_cnt = w_alloc_cnt + c_ptr_w'(v_run);
      end
   end

   lane_compactor #(
      .LANES (RET_W),
      .CNT_W (c_rcnt_w)
   ) u_ret_compactor (
      .valid  (ret_valid),
      .offset (w_ret_off),
      .total  (w_ret_total)
   );

   assign w_ret_cnt = c_ptr_w'(w_ret_total);

   generate
      for (genvar j = 0; j < RET_W; j++) begin : g_ret_lane
         logic [c_ptr_w-1:0] w_wr_ptr;
         assign w_wr_ptr    = r_tail + c_ptr_w'(w_ret_off[j]);
         assign w_wr_idx[j] = w_wr_ptr[c_idx_w-1:0];
      end
   endgenerate

   assign w_head_alloc = r_head + w_alloc_cnt;
   assign w_ckpt_sel   = r_ckpt_head[ckpt_tag];

   // Recovery lands on the committed head including the lanes retiring this cycle.
   always_comb begin
      w_head_nxt = w_head_alloc;
      if (recov_arch_st) begin
         w_head_nxt = r_commit_head + w_ret_cnt;
      end else if (ckpt_restore) begin
         w_head_nxt = w_ckpt_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < FL_DEPTH; k++) begin
            r_ring[k] <= c_prf_w'(ARF_DEPTH + k);
         end
         r_head        <= '0;
         r_commit_head <= '0;
         r_tail        <= c_ptr_w'(FL_DEPTH);
         for (int c = 0; c < NUM_CKPT; c++) begin
            r_ckpt_head[c] <= '0;
         end
      end else begin
         r_head        <= w_head_nxt;
         r_tail        <= r_tail + w_ret_cnt;
         r_commit_head <= r_commit_head + w_ret_cnt;
         for (int j = 0; j < RET_W; j++) begin
            if (ret_valid[j]) begin
               r_ring[w_wr_idx[j]] <= ret_prn_prev[j];
            end
         end
         if (ckpt_save && !w_alloc_block) begin
            r_ckpt_head[ckpt_tag] <= w_head_alloc;
         end
      end
   end

   assign w_rst_dist  = w_ckpt_sel - r_commit_head;
   assign w_head_dist = r_head - r_commit_head;

   a_free_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
      free_cnt <= c_ptr_w'(FL_DEPTH));

   a_restore_range: assert property (@(posedge clk) disable iff (!rst_n)
      (ckpt_restore && !recov_arch_st) |-> (w_rst_dist <= w_head_dist));

endmodule
`default_nettype wire

// File: tb/tb_prn_free_list_ckpt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prn_free_list_ckpt                                                      |
// | Directed bench with a reference model and expected-PRN scoreboard queue.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_prn_free_list_ckpt;

   logic       clk;
   logic       rst_n;
   logic [5:0] alloc_prn [2];
   logic [1:0] alloc_valid;
   logic [1:0] alloc_ready;
   logic [5:0] ret_prn_prev [2];
   logic [1:0] ret_valid;
   logic       ckpt_save;
   logic       ckpt_restore;
   logic [1:0] ckpt_tag;
   logic       recov_arch_st;
   logic [5:0] free_cnt;

   int checks = 0;
   int errors = 0;

   int m_ring [32];
   int m_head, m_tail, m_commit;
   int m_ckpt [4];
   int exp_q [$];

   prn_free_list_ckpt dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alloc_prn     (alloc_prn),
      .alloc_valid   (alloc_valid),
      .alloc_ready   (alloc_ready),
      .ret_prn_prev  (ret_prn_prev),
      .ret_valid     (ret_valid),
      .ckpt_save     (ckpt_save),
      .ckpt_restore  (ckpt_restore),
      .ckpt_tag      (ckpt_tag),
      .recov_arch_st (recov_arch_st),
      .free_cnt      (free_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic drive_idle();
      alloc_ready     = 2'b00;
      ret_valid       = 2'b00;
      ret_prn_prev[0] = 6'd0;
      ret_prn_prev[1] = 6'd0;
      ckpt_save       = 1'b0;
      ckpt_restore    = 1'b0;
      ckpt_tag        = 2'd0;
      recov_arch_st   = 1'b0;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 32; k++) m_ring[k] = 32 + k;
      m_head   = 0;
      m_commit = 0;
      m_tail   = 32;
      for (int c = 0; c < 4; c++) m_ckpt[c] = 0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst_n = 1'b0;
      model_reset();
      #3;
      chk("rst_free_cnt", 32'(free_cnt), 32);
      chk("rst_alloc_valid", 32'(alloc_valid), 0);
      chk("rst_alloc_prn0", 32'(alloc_prn[0]), 32);
      chk("rst_alloc_prn1", 32'(alloc_prn[1]), 33);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock of stimulus: check outputs against the model, then advance the model.
   task automatic step(input logic [1:0] rdy, input logic [1:0] rv, input int p0, input int p1,
                       input logic sv, input logic rs, input int tag, input logic rc);
      int         free_exp, grant, rcnt, head_prev;
      logic [1:0] vexp;
      bit         run;
      int         pv [2];
      @(negedge clk);
      alloc_ready     = rdy;
      ret_valid       = rv;
      ret_prn_prev[0] = 6'(p0);
      ret_prn_prev[1] = 6'(p1);
      ckpt_save       = sv;
      ckpt_restore    = rs;
      ckpt_tag        = 2'(tag);
      recov_arch_st   = rc;
      #2;
      free_exp = m_tail - m_head;
      grant    = 0;
      run      = 1'b1;
      for (int i = 0; i < 2; i++) begin
         vexp[i] = (free_exp > i) && !rc && !rs;
         run     = run && vexp[i] && rdy[i];
         if (run) begin
            exp_q.push_back(m_ring[(m_head + i) % 32]);
            grant++;
         end
      end
      chk("free_cnt", 32'(free_cnt), 32'(free_exp));
      chk("alloc_valid", 32'(alloc_valid), 32'(vexp));
      for (int i = 0; i < grant; i++) begin
         chk($sformatf("alloc_prn%0d", i), 32'(alloc_prn[i]), 32'(exp_q.pop_front()));
      end
      pv[0] = p0;
      pv[1] = p1;
      rcnt  = 0;
      for (int j = 0; j < 2; j++) begin
         if (rv[j]) begin
            m_ring[(m_tail + rcnt) % 32] = pv[j];
            rcnt++;
         end
      end
      head_prev = m_head;
      if (rc)      m_head = m_commit + rcnt;
      else if (rs) m_head = m_ckpt[tag];
      else         m_head = m_head + grant;
      if (sv && !rs && !rc) m_ckpt[tag] = head_prev + grant;
      m_tail   += rcnt;
      m_commit += rcnt;
   endtask

   task automatic alloc2();
      step(2'b11, 2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic peek();
      @(negedge clk);
      drive_idle();
      #2;
   endtask

   initial begin
      drive_idle();
      rst_n = 1'b1;
      #1;

      // 1: drain the whole pool two at a time
      do_reset();
      for (int n = 0; n < 16; n++) alloc2();
      peek();
      chk("t1_free_cnt_empty", 32'(free_cnt), 0);
      chk("t1_alloc_valid_empty", 32'(alloc_valid), 0);

      // 2: one entry left, both lanes ready
      do_reset();
      for (int n = 0; n < 15; n++) alloc2();
      step(2'b01, 2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      peek();
      chk("t2_partial_valid", 32'(alloc_valid), 1);
      chk("t2_partial_prn", 32'(alloc_prn[0]), 63);
      step(2'b11, 2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      peek();
      chk("t2_free_cnt_after", 32'(free_cnt), 0);

      // 3: single-lane release on lane 1, gap in ready, wrap to the released PRN
      do_reset();
      alloc2();
      alloc2();
      step(2'b10, 2'b10, 0, 7, 1'b0, 1'b0, 0, 1'b0);
      peek();
      chk("t3_free_cnt_release", 32'(free_cnt), 29);
      step(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b1);
      peek();
      chk("t3_recov_prn", 32'(alloc_prn[0]), 33);
      for (int n = 0; n < 15; n++) alloc2();
      step(2'b01, 2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      peek();
      chk("t3_wrapped_prn", 32'(alloc_prn[0]), 7);
      chk("t3_wrapped_free", 32'(free_cnt), 1);

      // 4: checkpoint save together with allocation, then restore
      do_reset();
      alloc2();
      step(2'b11, 2'b00, 0, 0, 1'b1, 1'b0, 1, 1'b0);
      alloc2();
      alloc2();
      step(2'b11, 2'b00, 0, 0, 1'b1, 1'b1, 1, 1'b0);
      peek();
      chk("t4_restore_prn0", 32'(alloc_prn[0]), 36);
      chk("t4_restore_prn1", 32'(alloc_prn[1]), 37);
      chk("t4_restore_free", 32'(free_cnt), 28);
      alloc2();

      // 5: architectural recovery with a retire in the same cycle
      do_reset();
      alloc2();
      alloc2();
      alloc2();
      step(2'b00, 2'b11, 10, 11, 1'b0, 1'b0, 0, 1'b0);
      step(2'b11, 2'b01, 12, 0, 1'b1, 1'b0, 2, 1'b1);
      peek();
      chk("t5_recov_free", 32'(free_cnt), 32);
      chk("t5_recov_prn0", 32'(alloc_prn[0]), 35);
      chk("t5_recov_valid", 32'(alloc_valid), 3);

      // 6: asynchronous reset in the middle of a burst
      do_reset();
      alloc2();
      alloc2();
      step(2'b11, 2'b01, 5, 0, 1'b0, 1'b0, 0, 1'b0);
      @(posedge clk);
      #2;
      drive_idle();
      rst_n = 1'b0;
      #1;
      chk("t6_async_free", 32'(free_cnt), 32);
      chk("t6_async_valid", 32'(alloc_valid), 0);
      chk("t6_async_prn0", 32'(alloc_prn[0]), 32);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      peek();
      chk("t6_post_prn0", 32'(alloc_prn[0]), 32);
      chk("t6_post_prn1", 32'(alloc_prn[1]), 33);
      alloc2();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/prn_free_list_ckpt.md
Name: prn_free_list_ckpt

Overview:
- Parametrised successor of the current rename free list.
- Circular pool of free physical register numbers (PRNs) with N-wide in-order allocation and M-wide retire release.
- Supports branch checkpoints: save/restore of the allocation head, so a mispredict recovers in one cycle without an architectural flush.
- Sits between the decoder/RAT (allocation side) and the ROB (retire side); full architectural recovery rewinds to the committed head.

Parameters:
- ALLOC_W, 2, allocation lanes per cycle (rename width)
- RET_W, 2, retire/release lanes per cycle
- PRF_DEPTH, 64, physical registers
- ARF_DEPTH, 32, architectural registers
- NUM_CKPT, 4, branch checkpoint slots
- FL_DEPTH, PRF_DEPTH-ARF_DEPTH, ring entries; must be a power of two
- PRF_W / PTR_W / CKPT_W, derived: clog2(PRF_DEPTH), clog2(FL_DEPTH)+1, clog2(NUM_CKPT)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_prn[0:ALLOC_W-1]  out  PRF_W  candidate free PRN per lane
- alloc_valid  out  ALLOC_W  lane i has a PRN available
- alloc_ready  in  ALLOC_W  consumer takes lane i
- ret_prn_prev[0:RET_W-1]  in  PRF_W  previous mapping freed at retire
- ret_valid  in  RET_W  retire lane carries a dest-writing instruction
- ckpt_save  in  1  snapshot head into slot ckpt_tag
- ckpt_restore  in  1  rewind head from slot ckpt_tag
- ckpt_tag  in  CKPT_W  checkpoint slot index
- recov_arch_st  in  1  full architectural recovery
- free_cnt  out  PTR_W  number of free PRNs (registered state)

Behaviour:
- State:
  - ring[FL_DEPTH] of PRF_W.
  - Pointers head, commit_head, tail, each PTR_W with a wrap bit.
  - ckpt_head[NUM_CKPT].
- Reset (async, rst_n low):
  - ring[k] = ARF_DEPTH+k.
  - head = commit_head = 0; tail = FL_DEPTH (wrap bit set).
  - ckpt_head[*] = 0; free_cnt = FL_DEPTH.
  - Outputs: alloc_valid = 0 while in reset; alloc_prn[i] = ARF_DEPTH+i.
- Combinational outputs:
  - free_cnt = tail-head.
  - alloc_prn[i] = ring[(head+i) mod FL_DEPTH].
  - alloc_valid[i] = (free_cnt > i) & ~recov_arch_st & ~ckpt_restore.
- Allocation:
  - Granted lanes = leading contiguous prefix with alloc_valid & alloc_ready.
  - A ready lane after a gap is not consumed.
  - head += granted count.
  - PRN is handed out the same cycle (zero latency); pointer update at the clock edge.
- Release:
  - Valid retire lanes are compacted in lane order and written at tail, tail+1, ...
  - tail += popcount(ret_valid); commit_head += the same count.
  - Invariant tail-commit_head == FL_DEPTH always holds, so each write overwrites only a just-committed slot.
  - Release has no ready; it is always accepted.
- Checkpoint save:
  - ckpt_head[ckpt_tag] <= head after this cycle's allocations, i.e. the branch is the last instruction of the group.
  - Save is ignored if ckpt_restore or recov_arch_st is high in the same cycle.
- Restore: head <= ckpt_head[ckpt_tag]; no allocation that cycle.
- Recovery: head <= commit_head plus this cycle's retire count; no allocation that cycle.
- Priority: recov_arch_st > ckpt_restore > allocation. Retire release is always applied, including in flush and restore cycles.
- Pointer arithmetic: modulo 2*FL_DEPTH; index = low clog2(FL_DEPTH) bits.
- Boundary cases:
  - Empty (free_cnt=0): all alloc_valid low.
  - Partial (free_cnt=1): only lane 0 valid.
  - Full: free_cnt=FL_DEPTH.
- Assertions:
  - free_cnt never exceeds FL_DEPTH.
  - Restored head lies within [commit_head, head].

Decomposition:
- Shared package holds PRF_W, PTR_W, and a FREE_LIST_CKPT typedef (head pointer, valid).
- Natural sub-module: lane_compactor, a prefix-sum of ret_valid producing a write offset per lane; it is reused by the RAT checkpoint work.

Test Plan:
1. Reset, both lanes ready each cycle for 16 cycles -> PRNs 32,33 ... 62,63 issued; free_cnt reaches 0; alloc_valid=00.
2. free_cnt=1 with alloc_ready=11 -> only lane 0 granted (PRN 63); free_cnt=0 next cycle.
3. After 4 allocs, ret_valid=10 with ret_prn_prev[1]=7 -> PRN 7 written at tail index 0; free_cnt +1; commit_head +1.
4. Alloc 2 (head=2), ckpt_save tag 1 with alloc_ready=11 in the same cycle (head→4), alloc 4 more (head=8), ckpt_restore tag 1 -> head=4; next cycle alloc_prn = 36,37.
5. Alloc 6, retire 2, then recov_arch_st with ret_valid=01 -> head=commit_head=3; free_cnt=32; alloc_valid=00 during the flush cycle.
6. rst_n dropped mid-burst asynchronously -> pointers and free_cnt=32 immediately; ring restored to 32..63 after release.
